// File: rtl/ip_rx.sv
// IPv4 receive parser: validates and strips the IPv4 header of MAC payload
// frames and forwards the IP payload, tagged with UDP/ICMP destination and
// MAC/IP error flags.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for byte 0 (version/IHL) of the next frame
// HDR     | collecting header fields and summing the header checksum
// PAYLOAD | forwarding payload bytes through the output register
// PAD     | payload complete, last byte held, discarding Ethernet padding
// DROP    | rejected frame, discarding bytes until tlast
module ip_rx #(
  parameter logic [31:0] LOCAL_IP = 32'hC0A8_0164
) (
  input  logic        rx_mac_aclk,
  input  logic        rx_mac_reset,
  input  logic [7:0]  rx_axis_mac_tdata,
  input  logic        rx_axis_mac_tvalid,
  input  logic        rx_axis_mac_tlast,
  input  logic        rx_axis_mac_tuser,
  output logic [7:0]  rx_ip_proto,
  output logic [31:0] rx_ip_src_addr,
  output logic [7:0]  rx_axis_ip_tdata,
  output logic        rx_axis_ip_tvalid,
  output logic        rx_axis_ip_tlast,
  output logic [1:0]  rx_axis_ip_tuser,
  output logic        rx_axis_ip_tdest
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_PAD     = 3'd3;
  localparam logic [2:0] S_DROP    = 3'd4;

  logic [2:0]  state;
  logic [3:0]  ihl;
  logic [5:0]  hdr_cnt;
  logic [7:0]  hi_byte;
  logic [15:0] csum;
  logic [15:0] total_len;
  logic [13:0] frag;
  logic [7:0]  proto_r;
  logic [31:0] src_r;
  logic [31:0] dst_r;
  logic [15:0] rem_cnt;

  logic [16:0] csum_add;
  logic [15:0] csum_fold;
  logic [5:0]  hdr_len;
  logic [5:0]  hdr_last;
  logic [31:0] dst_now;
  logic [15:0] payload_len;
  logic        accept;

  // Header checksum fold and accept decision for the byte currently on the bus
  always_comb begin
    csum_add    = {1'b0, csum} + {1'b0, hi_byte, rx_axis_mac_tdata};
    // A 17-bit sum never exceeds 0x1FFFE, so one end-around fold is enough.
    csum_fold   = csum_add[15:0] + {15'd0, csum_add[16]};
    hdr_len     = {ihl, 2'b00};
    hdr_last    = hdr_len - 6'd1;
    // With IHL=5 the last dst byte and the decision arrive together.
    dst_now     = (hdr_cnt == 6'd19) ? {dst_r[23:0], rx_axis_mac_tdata} : dst_r;
    payload_len = total_len - {10'd0, hdr_len};
    accept      = (csum_fold == 16'hFFFF) &&
                  ((dst_now == LOCAL_IP) || (dst_now == 32'hFFFF_FFFF)) &&
                  ((proto_r == 8'd1) || (proto_r == 8'd17)) &&
                  (frag == 14'd0) &&
                  (total_len > {10'd0, hdr_len});
  end

  // Parser state, header field capture and per-packet metadata
  always_ff @(posedge rx_mac_aclk or posedge rx_mac_reset) begin
    if (rx_mac_reset) begin
      state            <= S_IDLE;
      ihl              <= 4'd0;
      hdr_cnt          <= 6'd0;
      hi_byte          <= 8'd0;
      csum             <= 16'd0;
      total_len        <= 16'd0;
      frag             <= 14'd0;
      proto_r          <= 8'd0;
      src_r            <= 32'd0;
      dst_r            <= 32'd0;
      rem_cnt          <= 16'd0;
      rx_ip_proto      <= 8'd0;
      rx_ip_src_addr   <= 32'd0;
      rx_axis_ip_tdest <= 1'b0;
    end else if (rx_axis_mac_tvalid) begin
      case (state)
        S_IDLE: begin
          hdr_cnt <= 6'd1;
          csum    <= 16'd0;
          hi_byte <= rx_axis_mac_tdata;
          ihl     <= rx_axis_mac_tdata[3:0];
          if (!rx_axis_mac_tlast) begin
            // Bad version or short IHL cannot be a valid header; skip the frame.
            if (rx_axis_mac_tdata[7:4] == 4'd4 && rx_axis_mac_tdata[3:0] >= 4'd5)
              state <= S_HDR;
            else
              state <= S_DROP;
          end
        end
        S_HDR: begin
          hdr_cnt <= hdr_cnt + 6'd1;
          if (hdr_cnt[0])
            csum <= csum_fold;
          else
            hi_byte <= rx_axis_mac_tdata;
          case (hdr_cnt)
            6'd2:  total_len[15:8] <= rx_axis_mac_tdata;
            6'd3:  total_len[7:0]  <= rx_axis_mac_tdata;
            6'd6:  frag[13:8]      <= rx_axis_mac_tdata[5:0];
            6'd7:  frag[7:0]       <= rx_axis_mac_tdata;
            6'd9:  proto_r         <= rx_axis_mac_tdata;
            6'd12, 6'd13, 6'd14, 6'd15: src_r <= {src_r[23:0], rx_axis_mac_tdata};
            6'd16, 6'd17, 6'd18, 6'd19: dst_r <= {dst_r[23:0], rx_axis_mac_tdata};
            default: ;
          endcase
          if (rx_axis_mac_tlast) begin
            state <= S_IDLE;
          end else if (hdr_cnt == hdr_last) begin
            if (accept) begin
              rx_ip_proto      <= proto_r;
              rx_ip_src_addr   <= src_r;
              rx_axis_ip_tdest <= (proto_r == 8'd1);
              rem_cnt          <= payload_len;
              state            <= S_PAYLOAD;
            end else begin
              state <= S_DROP;
            end
          end
        end
        S_PAYLOAD: begin
          rem_cnt <= rem_cnt - 16'd1;
          if (rx_axis_mac_tlast)
            state <= S_IDLE;
          else if (rem_cnt == 16'd1)
            state <= S_PAD;
        end
        S_PAD, S_DROP: begin
          if (rx_axis_mac_tlast)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // One-byte output register; the final payload byte is held through padding
  always_ff @(posedge rx_mac_aclk or posedge rx_mac_reset) begin
    if (rx_mac_reset) begin
      rx_axis_ip_tdata  <= 8'd0;
      rx_axis_ip_tvalid <= 1'b0;
      rx_axis_ip_tlast  <= 1'b0;
      rx_axis_ip_tuser  <= 2'b00;
    end else begin
      rx_axis_ip_tvalid <= 1'b0;
      rx_axis_ip_tlast  <= 1'b0;
      rx_axis_ip_tuser  <= 2'b00;
      if (rx_axis_mac_tvalid) begin
        if (state == S_PAYLOAD) begin
          rx_axis_ip_tdata <= rx_axis_mac_tdata;
          if (rx_axis_mac_tlast) begin
            rx_axis_ip_tvalid <= 1'b1;
            rx_axis_ip_tlast  <= 1'b1;
            // Frame ended before the IP length was satisfied: truncated packet.
            rx_axis_ip_tuser  <= {rem_cnt != 16'd1, rx_axis_mac_tuser};
          end else if (rem_cnt != 16'd1) begin
            rx_axis_ip_tvalid <= 1'b1;
          end
        end else if (state == S_PAD && rx_axis_mac_tlast) begin
          rx_axis_ip_tvalid <= 1'b1;
          rx_axis_ip_tlast  <= 1'b1;
          rx_axis_ip_tuser  <= {1'b0, rx_axis_mac_tuser};
        end
      end
    end
  end

endmodule

// File: tb/tb_ip_rx.sv
// Self-checking bench for ip_rx: frames are built with a reference checksum,
// expected payload bytes are queued as they are driven and compared on output.
`timescale 1ns/1ps
module tb_ip_rx;

  localparam logic [31:0] LOCAL_IP = 32'hC0A8_0164;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_user;
  logic [7:0]  rx_ip_proto;
  logic [31:0] rx_ip_src_addr;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic [1:0]  out_user;
  logic        out_dest;

  ip_rx #(.LOCAL_IP(LOCAL_IP)) dut (
    .rx_mac_aclk        (clk),
    .rx_mac_reset       (rst),
    .rx_axis_mac_tdata  (in_data),
    .rx_axis_mac_tvalid (in_valid),
    .rx_axis_mac_tlast  (in_last),
    .rx_axis_mac_tuser  (in_user),
    .rx_ip_proto        (rx_ip_proto),
    .rx_ip_src_addr     (rx_ip_src_addr),
    .rx_axis_ip_tdata   (out_data),
    .rx_axis_ip_tvalid  (out_valid),
    .rx_axis_ip_tlast   (out_last),
    .rx_axis_ip_tuser   (out_user),
    .rx_axis_ip_tdest   (out_dest)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [1:0] user;
    int         t;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  frm[$];
  logic [7:0]  exp_proto;
  logic [31:0] exp_src;
  logic        exp_dest;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic l, input logic [1:0] u, input int t);
    exp_t e;
    e.data = d; e.last = l; e.user = u; e.t = t;
    sb.push_back(e);
  endtask

  // Output monitor: every valid output byte must match the head of the queue
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_byte", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("tdata", out_data, e.data);
        chk("tlast", out_last, e.last);
        chk("tuser", out_user, e.user);
        chk("tdest", out_dest, exp_dest);
        chk("cycle", cyc, e.t);
        if (e.last) begin
          chk("proto", rx_ip_proto, exp_proto);
          chk("src", rx_ip_src_addr, exp_src);
        end
      end
    end
  end

  // Build a frame in frm: header with correct checksum, options, payload, padding
  task automatic build(input int ihl, input int tl, input logic [7:0] proto,
                       input logic [31:0] src, input logic [31:0] dst,
                       input logic [15:0] ff, input int flen, input bit fill_a5);
    logic [31:0] s;
    logic [15:0] cs;
    logic [15:0] tl16;
    tl16 = tl[15:0];
    frm.delete();
    frm.push_back({4'd4, ihl[3:0]}); frm.push_back(8'h00);
    frm.push_back(tl16[15:8]);       frm.push_back(tl16[7:0]);
    frm.push_back(8'h12);            frm.push_back(8'h34);
    frm.push_back(ff[15:8]);         frm.push_back(ff[7:0]);
    frm.push_back(8'h40);            frm.push_back(proto);
    frm.push_back(8'h00);            frm.push_back(8'h00);
    for (int k = 3; k >= 0; k--) frm.push_back(src[k*8 +: 8]);
    for (int k = 3; k >= 0; k--) frm.push_back(dst[k*8 +: 8]);
    for (int k = 0; k < (ihl - 5) * 4; k++) frm.push_back(8'h11 + k[7:0]);
    s = 32'd0;
    for (int i = 0; i < ihl * 4; i += 2) s = s + {16'd0, frm[i], frm[i+1]};
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    cs = ~s[15:0];
    frm[10] = cs[15:8];
    frm[11] = cs[7:0];
    for (int i = ihl * 4; i < flen; i++) begin
      int v;
      v = i * 13 + 5;
      if (i < tl) frm.push_back(fill_a5 ? 8'hA5 : v[7:0]);
      else        frm.push_back(8'h00);
    end
  endtask

  // Drive frm[start..stop-1]; queue expected output when the packet is accepted
  task automatic send(input bit acc, input int start, input int stop, input logic err,
                      input bit gaps, input int hdr, input int tl);
    int npay;
    int flen;
    logic [7:0] held;
    npay = tl - hdr;
    flen = frm.size();
    held = 8'h00;
    for (int i = start; i < stop; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
          in_valid = 1'b0; in_last = 1'b0; in_user = 1'b0;
        end
      end
      @(posedge clk); #1;
      in_data  = frm[i];
      in_valid = 1'b1;
      in_last  = (i == flen - 1);
      in_user  = (i == flen - 1) ? err : 1'b0;
      if (acc && i >= hdr) begin
        if (i < hdr + npay) begin
          if (i == hdr + npay - 1 && i != flen - 1)
            held = frm[i];
          else if (i == flen - 1)
            push_exp(frm[i], 1'b1, {i != hdr + npay - 1, err}, cyc + 1);
          else
            push_exp(frm[i], 1'b0, 2'b00, cyc + 1);
        end else if (i == flen - 1) begin
          push_exp(held, 1'b1, {1'b0, err}, cyc + 1);
        end
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_user = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (4) @(posedge clk);
    #1;
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; in_user = 1'b0;
    exp_proto = 8'd0; exp_src = 32'd0; exp_dest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", out_valid, 0);
    chk("rst_tlast", out_last, 0);
    chk("rst_tuser", out_user, 0);
    chk("rst_proto", rx_ip_proto, 0);
    chk("rst_src", rx_ip_src_addr, 0);
    chk("rst_tdest", out_dest, 0);
    rst = 1'b0;

    // UDP, no padding
    build(5, 46, 8'd17, 32'h0A00_0001, LOCAL_IP, 16'h0000, 46, 0);
    exp_proto = 8'd17; exp_src = 32'h0A00_0001; exp_dest = 1'b0;
    send(1, 0, 46, 1'b0, 0, 20, 46);
    drain("udp_drain");

    // ICMP, padded frame with MAC error
    build(5, 28, 8'd1, 32'h0A00_0002, LOCAL_IP, 16'h0000, 46, 0);
    exp_proto = 8'd1; exp_src = 32'h0A00_0002; exp_dest = 1'b1;
    send(1, 0, 46, 1'b1, 0, 20, 28);
    drain("icmp_drain");

    // Rejects: checksum bit flip, foreign dst, MF set, unsupported proto
    build(5, 46, 8'd17, 32'h0B00_0001, LOCAL_IP, 16'h0000, 46, 0);
    frm[8] = frm[8] ^ 8'h01;
    send(0, 0, 46, 1'b0, 0, 20, 46);
    drain("csum_drain");
    chk("csum_proto_kept", rx_ip_proto, 8'd1);
    chk("csum_src_kept", rx_ip_src_addr, 32'h0A00_0002);

    build(5, 46, 8'd17, 32'h0B00_0002, 32'hC0A8_0107, 16'h0000, 46, 0);
    send(0, 0, 46, 1'b0, 0, 20, 46);
    drain("dst_drain");
    chk("dst_proto_kept", rx_ip_proto, 8'd1);

    build(5, 46, 8'd17, 32'h0B00_0003, LOCAL_IP, 16'h2000, 46, 0);
    send(0, 0, 46, 1'b0, 0, 20, 46);
    drain("mf_drain");
    chk("mf_proto_kept", rx_ip_proto, 8'd1);

    build(5, 46, 8'd6, 32'h0B00_0004, LOCAL_IP, 16'h0000, 46, 0);
    send(0, 0, 46, 1'b0, 0, 20, 46);
    drain("tcp_drain");
    chk("tcp_proto_kept", rx_ip_proto, 8'd1);

    // Truncated packet
    build(5, 100, 8'd17, 32'h0A00_0003, LOCAL_IP, 16'h0000, 60, 0);
    exp_proto = 8'd17; exp_src = 32'h0A00_0003; exp_dest = 1'b0;
    send(1, 0, 60, 1'b0, 0, 20, 100);
    drain("trunc_drain");

    // IHL=6 with options, broadcast, random input gaps
    build(6, 64, 8'd17, 32'h0A00_0004, 32'hFFFF_FFFF, 16'h0000, 64, 0);
    exp_proto = 8'd17; exp_src = 32'h0A00_0004; exp_dest = 1'b0;
    send(1, 0, 64, 1'b0, 1, 24, 64);
    drain("opt_drain");

    // Reset in the middle of the payload
    build(5, 46, 8'd17, 32'h0A00_0005, LOCAL_IP, 16'h0000, 46, 1);
    exp_proto = 8'd17; exp_src = 32'h0A00_0005; exp_dest = 1'b0;
    send(1, 0, 30, 1'b0, 0, 20, 46);
    #1;
    chk("pre_rst_tvalid", out_valid, 1);
    chk("pre_rst_queue", sb.size(), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", out_valid, 0);
    chk("mid_rst_tlast", out_last, 0);
    chk("mid_rst_tuser", out_user, 0);
    chk("mid_rst_proto", rx_ip_proto, 0);
    sb.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    send(0, 30, 46, 1'b0, 0, 20, 46);
    drain("remnant_drain");

    build(5, 46, 8'd17, 32'h0A00_0006, LOCAL_IP, 16'h0000, 46, 0);
    exp_proto = 8'd17; exp_src = 32'h0A00_0006; exp_dest = 1'b0;
    send(1, 0, 46, 1'b0, 0, 20, 46);
    drain("post_rst_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ip_rx.md
# ip_rx

IPv4 receive parser between the Ethernet MAC receive path and the UDP/ICMP receive stages. Consumes the MAC payload of frames already filtered to EtherType 0x0800, validates and strips the IPv4 header, and forwards the IP payload as a byte stream. Each packet is tagged with its destination (UDP or ICMP) and its error flags. It also publishes the protocol number and source address of the current packet.

## Interface
- LOCAL_IP, 32'hC0A8_0164, local IPv4 address (192.168.1.100) used for destination match.
- rx_mac_aclk  in  1  receive clock; all logic on rising edge.
- rx_mac_reset  in  1  asynchronous, active-high reset.
- rx_axis_mac_tdata  in  8  MAC payload byte; first byte is IPv4 version/IHL.
- rx_axis_mac_tvalid  in  1  byte valid; gaps allowed, no backpressure.
- rx_axis_mac_tlast  in  1  last byte of frame (includes Ethernet padding).
- rx_axis_mac_tuser  in  1  MAC error (FCS/PHY), qualified with tlast.
- rx_ip_proto  out  8  protocol field of the current accepted packet.
- rx_ip_src_addr  out  32  source address of the current accepted packet.
- rx_axis_ip_tdata  out  8  payload byte.
- rx_axis_ip_tvalid  out  1  payload byte valid.
- rx_axis_ip_tlast  out  1  last payload byte.
- rx_axis_ip_tuser  out  2  [0] MAC error, [1] IP error; qualified with tlast, 0 otherwise.
- rx_axis_ip_tdest  out  1  0 = UDP (proto 17), 1 = ICMP (proto 1); constant for the packet.

## Operation
- States: IDLE, HDR, PAYLOAD, PAD, DROP.
- IDLE: the first valid byte starts the header. Capture IHL = byte0[3:0] and version = byte0[7:4]. Byte counter = 1. Go to HDR.
- HDR: counts bytes 0..IHL*4-1.
  - Capture total_length from bytes 2–3, flags/frag offset from bytes 6–7, proto from byte 9, src from bytes 12–15, dst from bytes 16–19.
  - Option bytes are discarded.
  - Checksum: one's-complement sum of all 16-bit header words. Use a 17-bit accumulator with end-around carry folded each word. The header passes when the final sum is 16'hFFFF.
- Accept only if all of the following hold:
  - version==4 and IHL>=5.
  - Checksum passes.
  - dst==LOCAL_IP or dst==32'hFFFF_FFFF.
  - proto is 1 or 17.
  - MF==0 and frag offset==0.
  - total_length > IHL*4.
- Accept: load rx_ip_proto, rx_ip_src_addr and tdest. payload_len = total_length − IHL*4 (16-bit). Go to PAYLOAD.
- Reject: go to DROP with no output. rx_ip_proto and rx_ip_src_addr keep their previous values.
- Input tlast while in HDR goes to IDLE with no output.
- PAYLOAD: each input byte passes through a one-byte output register. A remaining-byte counter decrements per byte.
  - Counter reaches 0 on a byte that has in-tlast: emit it with tlast and tuser = {0, mac_err}. Go to IDLE.
  - Counter reaches 0 without in-tlast: hold the byte (tvalid low) and go to PAD.
  - In-tlast arrives before the counter reaches 0 (truncated packet): emit that byte with tlast and tuser = {1, mac_err}. Go to IDLE.
- PAD: discard Ethernet padding. On in-tlast, emit the held byte with tlast and tuser = {0, mac_err}. Go to IDLE.
- DROP: discard all bytes until in-tlast, then go to IDLE.
- Bytes with in-tvalid low are ignored in every state; counters do not move.
- Reset: asynchronous to IDLE. All outputs go to 0 immediately: tdata, tvalid, tlast, tuser, tdest, rx_ip_proto, rx_ip_src_addr.
  - A packet cut by reset never gets a tlast.
  - After release, a frame remnant is parsed as a header and is rejected by the checks.

## Timing
- Latency: one cycle from an input payload byte to its output.
- The held last byte appears one cycle after the input tlast of the padded frame.
- Output tvalid follows input tvalid gaps one cycle later. There is no output tready; downstream must always accept.
- rx_ip_proto, rx_ip_src_addr and tdest update in the cycle after the last header byte. They are stable at or before the first payload byte and hold until the next accepted header.
- Back-to-back frames are legal: an input byte in the cycle after in-tlast is a new header byte 0.

## Test plan
- UDP frame, IHL=5, total_length=46, dst=LOCAL_IP, no padding -> 26 bytes out:
  - equal to input bytes 20–45, each one cycle after input;
  - tlast on byte 26, tuser=00, tdest=0, rx_ip_proto=17.
- ICMP, total_length=28, frame padded to 46 bytes, rx_axis_mac_tuser=1 on tlast -> 8 bytes out, tdest=1, rx_ip_proto=1.
  - Byte 8 appears one cycle after the input tlast, with tlast=1 and tuser=01.
- Valid header with one checksum bit flipped; also dst=192.168.1.7; also MF=1 -> no output, rx_ip_proto unchanged.
- total_length=100 but frame ends at byte 60 -> 40 bytes out; byte 40 has tlast=1, tuser=10.
- IHL=6 with 4 option bytes, dst=255.255.255.255, random tvalid gaps -> payload starts at input byte 24; checksum covers the options; output gaps mirror input gaps.
- Reset asserted mid-payload -> tvalid/tlast/tuser=0 and rx_ip_proto=0 with no clock edge.
  - After release, the rest of the frame is dropped and the next valid frame is accepted normally.
